// File: rtl/t_pulse_gen.sv
// t_pulse_gen: emits a burst of COUNT single-cycle t pulses spaced PERIOD cycles apart for a downstream T flip-flop
module t_pulse_gen #(
  parameter int PW = 8,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] period,
  input  logic [NW-1:0] count,
  output logic          t,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] remaining
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  localparam logic [PW-1:0] P_ONE = 1;
  localparam logic [NW-1:0] N_ONE = 1;
  state_t state;
  logic [PW-1:0] div, p_lat;
  logic pulse;
  assign pulse = div == p_lat - P_ONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div       <= '0;
      p_lat     <= P_ONE;
      t         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      t    <= 1'b0;
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          p_lat     <= period == '0 ? P_ONE : period;
          remaining <= count;
          busy      <= 1'b1;
          div       <= '0;
          state     <= count == '0 ? FINISH : RUN;
        end
      end else if (abort) begin
        busy  <= 1'b0;
        state <= IDLE;
      end else if (state == FINISH) begin
        busy  <= 1'b0;
        done  <= 1'b1;
        state <= IDLE;
      end else if (pulse) begin
        t         <= 1'b1;
        div       <= '0;
        remaining <= remaining - N_ONE;
        state     <= remaining == N_ONE ? FINISH : RUN;
      end else begin
        div <= div + P_ONE;
      end
    end
  end
endmodule

// File: tb/tb_t_pulse_gen.sv
// tb_t_pulse_gen: scoreboard bench comparing t_pulse_gen against a timeline-based burst model
module tb_t_pulse_gen;
  logic clk = 1'b0;
  logic rst, start, abort;
  logic [7:0] period, count;
  logic t, busy, done;
  logic [7:0] remaining;

  t_pulse_gen #(.PW(8), .NW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .period(period), .count(count),
    .t(t), .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    logic t, busy, done;
    int rem;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  // model: a burst is described only by its start edge, P and N
  bit m_active = 0;
  int m_e0, m_p, m_n;
  int m_rem = 0;

  task automatic cyc(input logic r, input logic s, input logic a, input int p, input int c);
    exp_t e;
    int el;
    #1;
    rst = r; start = s; abort = a; period = 8'(p); count = 8'(c);
    @(posedge clk);
    cyc_n++;
    e.cyc = cyc_n; e.t = 0; e.busy = 0; e.done = 0;
    if (r) begin
      m_active = 0; m_rem = 0;
    end else if (m_active) begin
      el = cyc_n - m_e0;
      if (a) m_active = 0;
      else if (el == m_n * m_p + 1) begin
        m_active = 0; m_rem = 0; e.done = 1;
      end else begin
        e.busy = 1;
        e.t = (el % m_p == 0) && el >= m_p && el <= m_n * m_p;
        m_rem = m_n - el / m_p;
      end
    end else if (s) begin
      m_active = 1; m_e0 = cyc_n;
      m_p = (p % 256 == 0) ? 1 : p % 256;
      m_n = c % 256;
      m_rem = m_n; e.busy = 1;
    end
    e.rem = m_rem;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  task automatic burst(input int p, input int c);
    cyc(0, 1, 0, p, c);
    idle(c * (p == 0 ? 1 : p) + 3);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (t !== e.t || busy !== e.busy || done !== e.done || remaining !== 8'(e.rem)) begin
        miscompares++;
        $display("FAIL edge%0d outputs: got t=%b busy=%b done=%b rem=%0d, expected t=%b busy=%b done=%b rem=%0d",
                 e.cyc, t, busy, done, remaining, e.t, e.busy, e.done, e.rem);
      end
    end
  end

  initial begin
    int r, s, a, p, c;
    repeat (3) cyc(1, 0, 0, 0, 0);
    burst(3, 4);
    burst(1, 3);
    burst(0, 3);
    burst(5, 0);
    cyc(0, 1, 0, 4, 5);
    idle(5);
    cyc(0, 1, 0, 1, 9);
    idle(20);
    cyc(0, 1, 0, 2, 6);
    idle(5);
    cyc(0, 0, 1, 2, 6);
    idle(5);
    cyc(0, 1, 0, 3, 8);
    idle(6);
    cyc(1, 1, 1, 3, 8);
    cyc(0, 1, 0, 2, 1);
    idle(5);
    cyc(0, 1, 0, 2, 2);
    idle(4);
    cyc(0, 1, 1, 1, 2);
    idle(4);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199) == 0;
      s = $urandom_range(0, 3) == 0;
      a = $urandom_range(0, 24) == 0;
      p = $urandom_range(0, 9) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 5);
      c = $urandom_range(0, 7);
      cyc(r[0], s[0], a[0], p, c);
    end
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/t_pulse_gen.md
Name: t_pulse_gen

Overview:
Programmable toggle-enable generator that sits directly upstream of the team's T flip-flop (tff1) and drives its t input. On a start request it emits a burst of exactly COUNT single-cycle t pulses, spaced PERIOD clock cycles apart, then flags completion. The downstream T flip-flop therefore toggles exactly COUNT times, so its final q parity equals COUNT mod 2. The block gives the T-FF stage a controlled, countable stimulus source for divider and toggle-chain use.

Parameters:
PW, 8, width of the period input and of the internal divider counter.
NW, 8, width of the burst count input and of the remaining output.

Ports:
clk  input  1  single system clock; all state changes on its rising edge.
rst  input  1  synchronous, active-high reset; highest priority.
start  input  1  burst request; sampled only when the block is idle.
abort  input  1  terminates a running burst; sampled while busy.
period  input  PW  pulse spacing in cycles; latched when start is accepted.
count  input  NW  number of t pulses; latched when start is accepted.
t  output  1  toggle enable to the T-FF; one-cycle pulses.
busy  output  1  high from start acceptance until the burst ends.
done  output  1  one-cycle completion strobe.
remaining  output  NW  pulses still to be issued.

Behaviour:
- All outputs are registered. Reset value of every output: t=0, busy=0, done=0, remaining=0. The divider counter and state are also cleared (state=IDLE).
- rst asserted on any edge, including mid-burst, returns everything to the reset values at that edge. Any partial burst is discarded.
- FSM states:
  - IDLE (busy=0): done may be high for one cycle on entry.
  - RUN (busy=1): divider runs and pulses are issued.
  - FINISH (busy=1, t high on the last pulse).
- Effective period: P = period, except period==0 is treated as P=1.
- Accepting start (edge E0, state IDLE):
  - Latch P and N=count. Set remaining=N and busy=1. Clear the divider.
  - If N==0: at edge E0+1, busy=0 and done=1 for one cycle. No t pulse is issued.
- Pulse timing:
  - t rises at edges E0+k*P for k=1..N and is high for exactly one cycle. With P=1, t stays high continuously for N cycles.
  - remaining decrements at the same edge t rises, so it reads N-k while pulse k is high.
- Termination:
  - At edge E0+N*P+1: t=0, busy=0, done=1 for one cycle, state returns to IDLE.
  - remaining reads 0 at that point.
- start while busy is ignored. It is not queued, and period/count changes do not affect the running burst.
- start during the done cycle is accepted, because the state is already IDLE. Back-to-back bursts are allowed.
- abort while busy:
  - At the next edge: t=0, busy=0, done=0, state returns to IDLE.
  - remaining freezes at its current value.
  - abort wins over a pulse scheduled at the same edge, so no pulse is issued at that edge.
  - abort while idle has no effect.
- Simultaneous start and abort in IDLE: start is accepted.
- rst overrides start and abort on the same edge.
- Divider arithmetic is unsigned with PW-bit wrap. The divider never exceeds P-1.

Test Plan:
- rst, then period=3, count=4, start at E0 -> t high after E0+3, +6, +9, +12; remaining goes 3,2,1,0; done=1 and busy=0 after E0+13; downstream tff1 q toggles 4 times and ends at 0.
- period=1, count=3 -> t high for 3 consecutive cycles starting at E0+1; done at E0+4; downstream q ends at 1. Repeat with period=0 -> identical waveform.
- count=0, period=5 -> no t pulse; busy high for one cycle; done at E0+1.
- period=4, count=5, second start with period=1, count=9 at E0+6 -> ignored; original 5 pulses at 4-cycle spacing; remaining never reloads.
- period=2, count=6, abort held for one cycle at E0+5 -> pulses at E0+2 and E0+4 only; busy=0 after E0+6; done never asserted; remaining frozen at 4.
- rst asserted at E0+7 of a period=3, count=8 burst -> all outputs 0 at that edge. A new start with period=2, count=1 after rst deasserts gives a single pulse 2 cycles later and done one cycle after that pulse.
